// File: rtl/program_loader_if.sv
// Byte-stream and instruction-memory write bus of the program loader.
//
// Parameters:
//   N           instruction word / address width
//
// Signals:
//   byte_in     stream byte
//   byte_valid  byte_in carries a byte
//   byte_ready  loader can take a byte this cycle
//   mem_we      one-cycle instruction memory write strobe
//   mem_address byte address of the word being written
//   mem_wdata   word being written
//
// Handshake: a byte moves on a rising clk edge where byte_valid and
// byte_ready are both 1. The source keeps byte_in stable and byte_valid high
// until that edge; byte_ready never depends on byte_valid.
//
// Modports:
//   master  stream source / memory side (drives byte_in, byte_valid)
//   slave   the loader (drives byte_ready and the memory write bus)
interface program_loader_if #(
    parameter int N = 32
);
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_ready;
    logic         mem_we;
    logic [N-1:0] mem_address;
    logic [N-1:0] mem_wdata;

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  mem_we,
        input  mem_address,
        input  mem_wdata
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output mem_we,
        output mem_address,
        output mem_wdata
    );
endinterface

// File: rtl/program_loader.sv
// Boot-time program loader for the single-cycle processor.
//
// Receives a byte stream (2-byte big-endian word count C, then 4*C bytes,
// each word MSB first), writes the assembled words to consecutive word
// addresses of instruction memory and keeps the processor in reset (cpu_rst=0)
// until the image is complete.
//
// Optional feature: define LOADER_CHECKSUM_EN to append one checksum byte to
// the stream. It must equal the XOR of all header and data bytes, otherwise
// the load ends in ERROR.
//
// Parameters:
//   N       instruction word / address width
//   DEPTH   instruction memory capacity in words (C must not exceed it)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   start      one-cycle load request, honoured in IDLE, DONE or ERROR only
//   bus        stream handshake and memory write bus (slave side)
//   cpu_rst    active-low processor reset, 1 only after a successful load
//   busy       load in progress
//   done       image loaded successfully (level)
//   error      load aborted (level)
//   dbg_state  current FSM state encoding
module program_loader #(
    parameter int N     = 32,
    parameter int DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    program_loader_if.slave   bus,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [2:0]        dbg_state
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR_HI = 3'd1,
        S_HDR_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
`ifdef LOADER_CHECKSUM_EN
        S_CHK    = 3'd5,
`endif
        S_DONE   = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    state_t             state_q, state_d;
    state_t             after_image;
    logic [15:0]        count_q, count_d;
    logic [15:0]        hdr_c;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [N-1:0]       word_q, word_d;
    logic [N-1:0]       shifted;
    logic [N-1:0]       addr_q, addr_d;
    logic [N-1:0]       wdata_q, wdata_d;
    logic               xfer;
    logic               last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         chk_q, chk_d;
`endif

    // Outputs are pure decodes of the state, so reset values fall out of IDLE.
    assign bus.byte_ready  = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
`ifdef LOADER_CHECKSUM_EN
                             (state_q == S_CHK) ||
`endif
                             (state_q == S_DATA);
    assign bus.mem_we      = (state_q == S_WRITE);
    assign bus.mem_address = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign cpu_rst         = (state_q == S_DONE);
    assign done            = (state_q == S_DONE);
    assign error           = (state_q == S_ERROR);
    assign busy            = bus.byte_ready || (state_q == S_WRITE);
    assign dbg_state       = state_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        idx_d       = idx_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        chk_d       = chk_q;
        after_image = S_CHK;
`else
        after_image = S_DONE;
`endif
        xfer        = bus.byte_valid && bus.byte_ready;
        hdr_c       = {count_q[15:8], bus.byte_in};
        shifted     = {word_q[N-9:0], bus.byte_in};
        last_word   = ((16'(idx_q) + 16'd1) == count_q);

        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d    = S_HDR_HI;
                    count_d    = '0;
                    idx_d      = '0;
                    byte_cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    chk_d      = '0;
`endif
                end
            end
            S_HDR_HI: begin
                if (xfer) begin
                    count_d = {bus.byte_in, count_q[7:0]};
                    state_d = S_HDR_LO;
`ifdef LOADER_CHECKSUM_EN
                    chk_d   = chk_q ^ bus.byte_in;
`endif
                end
            end
            S_HDR_LO: begin
                if (xfer) begin
                    count_d = hdr_c;
`ifdef LOADER_CHECKSUM_EN
                    chk_d   = chk_q ^ bus.byte_in;
`endif
                    if (hdr_c > 16'(DEPTH)) begin
                        state_d = S_ERROR;
                    end else if (hdr_c == 16'd0) begin
                        state_d = after_image;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    word_d     = shifted;
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    chk_d      = chk_q ^ bus.byte_in;
`endif
                    // Latch the write bus here so it is valid for the whole
                    // WRITE cycle and then holds until the next word.
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                        wdata_d = shifted;
                        addr_d  = N'(idx_q) << 2;
                    end
                end
            end
            S_WRITE: begin
                if (last_word) begin
                    state_d = after_image;
                end else begin
                    // Only advance when another word follows, so the index
                    // stays within 0..DEPTH-1.
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (xfer) begin
                    state_d = (bus.byte_in == chk_q) ? S_DONE : S_ERROR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: header table, directed two-word image with
// latency and backpressure, mid-load reset, restart from DONE, full-depth and
// randomized images checked against a stream-level reference model.
module tb_program_loader;

    localparam int N     = 32;
    localparam int DEPTH = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       cpu_rst, busy, done, error;
    logic [2:0] dbg_state;

    program_loader_if #(.N(N)) bus ();

    program_loader #(.N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];   // {address, data} of each expected write
    logic [7:0]  img[$];     // stream bytes the driver sends next

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        bit         exp_err;
        bit         exp_done;
    } hdr_vec_t;

    hdr_vec_t hdr_tab[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every write strobe must match the head of exp_q, and the
    // loader may refuse bytes only while it writes.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.mem_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write addr=%0h data=%0h expected=none",
                             bus.mem_address, bus.mem_wdata);
                end else begin
                    check("write", {bus.mem_address, bus.mem_wdata}, exp_q.pop_front());
                end
            end
            if (busy) check("ready_vs_write", bus.byte_ready, !bus.mem_we);
        end
    end

    function automatic logic [7:0] xor_img(input int upto);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < upto; i++) x ^= img[i];
        return x;
    endfunction

    // Reference model: decode img by the stream rules, queue the writes it
    // implies and report whether the load should end in error.
    task automatic model_image(output bit exp_err);
        int c;
        c = int'({img[0], img[1]});
        exp_err = 1'b0;
        if (c > DEPTH) begin
            exp_err = 1'b1;
            return;
        end
        for (int w = 0; w < c; w++) begin
            logic [31:0] a;
            logic [31:0] d;
            a = 32'(w * 4);
            d = {img[2 + 4*w], img[3 + 4*w], img[4 + 4*w], img[5 + 4*w]};
            exp_q.push_back({a, d});
        end
`ifdef LOADER_CHECKSUM_EN
        exp_err = (img.size() > 2 + 4*c) ? (img[2 + 4*c] != xor_img(2 + 4*c)) : 1'b1;
`endif
    endtask

    task automatic add_chk(input bit corrupt);
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = xor_img(img.size());
        if (corrupt) x ^= 8'($urandom_range(1, 255));
        img.push_back(x);
`else
        if (corrupt) img.push_back(8'h00);
        img.delete(img.size() - 1 + int'(!corrupt));
`endif
    endtask

    task automatic build_image(input int c, input bit corrupt);
        img.delete();
        img.push_back(8'(c >> 8));
        img.push_back(8'(c));
        for (int i = 0; i < 4*c; i++) img.push_back(8'($urandom));
        add_chk(corrupt);
    endtask

    // gap_mode 0: valid held high; 1: valid low every other cycle with start
    // pulsed during the gaps; 2: random gaps.
    task automatic send_stream(input int gap_mode);
        for (int i = 0; i < img.size(); i++) begin
            int  budget = 0;
            bit  acc = 1'b0;
            int  gaps;
            gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            repeat (gaps) begin
                bus.byte_valid = 1'b0;
                bus.byte_in    = 8'($urandom);
                start          = (gap_mode == 1);
                step();
                start          = 1'b0;
            end
            bus.byte_in    = img[i];
            bus.byte_valid = 1'b1;
            while (!acc) begin
                acc = bus.byte_ready;
                step();
                budget++;
                if (!acc && budget > 50) begin
                    checks++;
                    errors++;
                    $display("FAIL byte_accept_timeout byte=%0d state=%0d expected=accepted", i, dbg_state);
                    bus.byte_valid = 1'b0;
                    return;
                end
            end
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_end(input bit exp_err);
        int n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        if (busy) $display("FAIL load_end_timeout state=%0d expected=not_busy", dbg_state);
        check("busy_end", busy, 1'b0);
        check("done", done, !exp_err);
        check("error", error, exp_err);
        check("cpu_rst", cpu_rst, !exp_err);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, bus.byte_ready, 1'b0);
        check({tag, "_we"}, bus.mem_we, 1'b0);
        check({tag, "_addr"}, bus.mem_address, '0);
        check({tag, "_wdata"}, bus.mem_wdata, '0);
        check({tag, "_cpu_rst"}, cpu_rst, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_error"}, error, 1'b0);
    endtask

    task automatic two_word_image();
        img.delete();
        img.push_back(8'h00); img.push_back(8'h02);
        img.push_back(8'h20); img.push_back(8'h08); img.push_back(8'h00); img.push_back(8'h05);
        img.push_back(8'h01); img.push_back(8'h09); img.push_back(8'h48); img.push_back(8'h20);
        add_chk(1'b0);
    endtask

    initial begin
        bit exp_err;

        hdr_tab[0] = '{8'h00, 8'h41, 1'b1, 1'b0};
        hdr_tab[1] = '{8'h01, 8'h00, 1'b1, 1'b0};
        hdr_tab[2] = '{8'hFF, 8'hFF, 1'b1, 1'b0};
        hdr_tab[3] = '{8'h80, 8'h00, 1'b1, 1'b0};
        hdr_tab[4] = '{8'h00, 8'h00, 1'b0, 1'b1};

        // Reset with a byte offered: nothing may be taken.
        bus.byte_in    = 8'hA5;
        bus.byte_valid = 1'b1;
        repeat (3) step();
        check_all_zero("in_reset");
        rst = 1'b1;
        step();
        check_all_zero("idle");
        bus.byte_valid = 1'b0;
        step();

        // Two-word image, valid held high, with write latency.
        two_word_image();
        model_image(exp_err);
        pulse_start();
        check("start_busy", busy, 1'b1);
        check("start_cpu_rst", cpu_rst, 1'b0);
        send_stream(0);
`ifdef LOADER_CHECKSUM_EN
        check("chk_done_now", done, 1'b1);
        check("chk_cpu_rst_now", cpu_rst, 1'b1);
`else
        check("we_latency", bus.mem_we, 1'b1);
        check("we_addr", bus.mem_address, 32'h4);
        check("we_data", bus.mem_wdata, 32'h01094820);
        step();
        check("done_after_write", done, 1'b1);
        check("cpu_rst_after_write", cpu_rst, 1'b1);
`endif
        wait_end(exp_err);

        // Restart from DONE, then same image under backpressure with start
        // pulses while busy.
        model_image(exp_err);
        pulse_start();
        check("restart_cpu_rst", cpu_rst, 1'b0);
        check("restart_busy", busy, 1'b1);
        check("restart_done", done, 1'b0);
        send_stream(1);
        wait_end(exp_err);

        // Header table: oversize counts and the empty image.
        for (int i = 0; i < 5; i++) begin
            img.delete();
            img.push_back(hdr_tab[i].hi);
            img.push_back(hdr_tab[i].lo);
            if (!hdr_tab[i].exp_err) add_chk(1'b0);
            pulse_start();
            send_stream(0);
            check($sformatf("hdr%0d_error", i), error, hdr_tab[i].exp_err);
            check($sformatf("hdr%0d_done", i), done, hdr_tab[i].exp_done);
            check($sformatf("hdr%0d_cpu_rst", i), cpu_rst, hdr_tab[i].exp_done);
            check($sformatf("hdr%0d_busy", i), busy, 1'b0);
            check($sformatf("hdr%0d_no_write", i), exp_q.size(), 0);
        end

        // Full-depth image.
        build_image(DEPTH, 1'b0);
        model_image(exp_err);
        pulse_start();
        send_stream(2);
        wait_end(exp_err);

`ifdef LOADER_CHECKSUM_EN
        // Wrong checksum byte, then a correct reload.
        two_word_image();
        img[img.size() - 1] = 8'h00;
        model_image(exp_err);
        pulse_start();
        send_stream(0);
        wait_end(exp_err);
        two_word_image();
        model_image(exp_err);
        pulse_start();
        send_stream(2);
        wait_end(exp_err);
`endif

        // Randomized images.
        for (int t = 0; t < 8; t++) begin
            build_image(int'($urandom_range(1, 8)), ($urandom_range(0, 3) == 0));
            model_image(exp_err);
            pulse_start();
            send_stream(int'($urandom_range(0, 2)));
            wait_end(exp_err);
        end

        // Reset after five data bytes: only word 0 was written.
        two_word_image();
        while (img.size() > 7) void'(img.pop_back());
        exp_q.push_back({32'h0, img[2], img[3], img[4], img[5]});
        pulse_start();
        send_stream(0);
        rst = 1'b0;
        #1;
        check_all_zero("mid_reset");
        step();
        rst = 1'b1;
        step();
        check_all_zero("after_reset");
        check("reset_queue_drained", exp_q.size(), 0);

        // Recovery load after the reset.
        build_image(3, 1'b0);
        model_image(exp_err);
        pulse_start();
        send_stream(2);
        wait_end(exp_err);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog state=%0d expected=finished", dbg_state);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

endmodule
